// File: rtl/pmem_line_responder_pkg.sv
// Shared types for the pmem line responder: line type, FSM states, latched op kind.
package pmem_line_responder_pkg;

   typedef logic [127:0] lc3b_line;
   typedef logic [15:0]  lc3b_word;

   typedef enum logic [1:0] {
      PMEM_IDLE,
      PMEM_BUSY,
      PMEM_RESP
   } pmem_state_t;

   typedef enum logic {
      PMEM_OP_READ,
      PMEM_OP_WRITE
   } pmem_op_t;

   localparam int unsigned CNT_BITS = 4;

   // Request line that must stay high for the latched op to keep going.
   function automatic logic line_req(input pmem_op_t op, input logic rd, input logic wr);
      return (op == PMEM_OP_READ) ? rd : wr;
   endfunction

endpackage

// File: rtl/pmem_line_responder_if.sv
// Cache-side pmem bus: master is the cache controller, slave is the memory responder.
interface pmem_line_responder_if;
   import pmem_line_responder_pkg::*;

   logic     pmem_read;
   logic     pmem_write;
   lc3b_word pmem_address;
   lc3b_line pmem_wdata;
   lc3b_line pmem_rdata;
   logic     pmem_resp;
   logic     pmem_busy;
   logic     pmem_error;

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp, pmem_busy, pmem_error
   );

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp, pmem_busy, pmem_error
   );

endinterface

// File: rtl/pmem_line_responder_line_array.sv
// Line storage with a resettable valid bitmap; invalid lines read back as zero.
module pmem_line_array
   import pmem_line_responder_pkg::*;
#(
   parameter int unsigned INDEX_BITS = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] waddr,
   input  lc3b_line              wdata,
   input  logic [INDEX_BITS-1:0] raddr,
   output lc3b_line              rdata
);

   localparam int unsigned LINES = 2 ** INDEX_BITS;

   lc3b_line          mem [LINES];
   logic [LINES-1:0]  valid;

   // NOTE: the data array has no reset so it maps onto block RAM; only the
   // valid bitmap is cleared, which is enough to make every line read as zero.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     valid        <= '0;
      else if (we) valid[waddr] <= 1'b1;
   end

   assign rdata = valid[raddr] ? mem[raddr] : '0;

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency physical-memory responder: one line request in flight, resp pulse on completion.
module pmem_line_responder
   import pmem_line_responder_pkg::*;
#(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned INDEX_BITS = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   pmem_line_responder_if.slave   bus
);

   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

   pmem_state_t           state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   pmem_op_t              op_q;
   logic [INDEX_BITS-1:0] index_q;
   lc3b_line              wdata_q;
   lc3b_line              rdata_q;
   logic                  error_q;

   logic     accept;
   logic     commit;
   logic     rd_done;
   logic     err_set;
   lc3b_line arr_rdata;

   // Byte-offset bits never select anything; the line is always whole.
   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.pmem_address[3:0];

   pmem_line_array #(.INDEX_BITS(INDEX_BITS)) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (commit),
      .waddr (index_q),
      .wdata (wdata_q),
      .raddr (index_q),
      .rdata (arr_rdata)
   );

   // NOTE: every signal gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      rd_done = 1'b0;
      err_set = 1'b0;
      case (state_q)
         PMEM_IDLE: begin
            if (bus.pmem_read || bus.pmem_write) begin
               accept  = 1'b1;
               err_set = bus.pmem_read && bus.pmem_write;
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? PMEM_RESP : PMEM_BUSY;
            end
         end
         PMEM_BUSY: begin
            if (!line_req(op_q, bus.pmem_read, bus.pmem_write)) begin
               // Requester gave up: drop the access without a resp or commit.
               cnt_d   = '0;
               state_d = PMEM_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == 1) state_d = PMEM_RESP;
            end
         end
         PMEM_RESP: begin
            commit  = (op_q == PMEM_OP_WRITE);
            rd_done = (op_q == PMEM_OP_READ);
            state_d = PMEM_IDLE;
         end
         default: state_d = PMEM_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PMEM_IDLE;
         cnt_q   <= '0;
         op_q    <= PMEM_OP_READ;
         index_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            // Read wins when both requests are high.
            op_q    <= bus.pmem_read ? PMEM_OP_READ : PMEM_OP_WRITE;
            index_q <= bus.pmem_address[INDEX_BITS+3:4];
            wdata_q <= bus.pmem_wdata;
         end
         if (rd_done) rdata_q <= arr_rdata;
         if (err_set) error_q <= 1'b1;
      end
   end

   // Read data shows through in the resp cycle and is held afterwards.
   assign bus.pmem_rdata = rd_done ? arr_rdata : rdata_q;
   assign bus.pmem_resp  = (state_q == PMEM_RESP);
   assign bus.pmem_busy  = (state_q != PMEM_IDLE);
   assign bus.pmem_error = error_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Randomized self-checking bench for pmem_line_responder against a line-level memory model.
module tb_pmem_line_responder;
   import pmem_line_responder_pkg::*;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pmem_line_responder_if bus();

   pmem_line_responder #(.LATENCY(LAT), .INDEX_BITS(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests  = 0;
   int failed = 0;

   // Reference memory: only written lines exist, everything else reads zero.
   lc3b_line ref_mem [int];

   function automatic lc3b_line ref_read(input logic [15:0] a);
      int idx;
      idx = int'(a[15:4]);
      return ref_mem.exists(idx) ? ref_mem[idx] : '0;
   endfunction

   function automatic void ref_write(input logic [15:0] a, input lc3b_line d);
      ref_mem[int'(a[15:4])] = d;
   endfunction

   // Drives one access from IDLE and reports edges-to-resp, busy cycles and resp-cycle rdata.
   task automatic run_access(input bit rd, input bit wr, input logic [15:0] addr,
                             input lc3b_line wd, input bit hold,
                             output int lat, output int busy_cnt, output lc3b_line rdat);
      lat = -1; busy_cnt = 0; rdat = '0;
      bus.pmem_read = rd; bus.pmem_write = wr;
      bus.pmem_address = addr; bus.pmem_wdata = wd;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         bus.pmem_address = 16'($urandom);
         bus.pmem_wdata   = {4{$urandom}};
         if (bus.pmem_busy) busy_cnt++;
         if (bus.pmem_resp) begin
            lat  = k;
            rdat = bus.pmem_rdata;
            break;
         end
      end
      if (!hold) begin
         bus.pmem_read = 1'b0; bus.pmem_write = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.pmem_read = 1'b0; bus.pmem_write = 1'b0;
      bus.pmem_address = '0; bus.pmem_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({bus.pmem_resp, bus.pmem_busy, bus.pmem_error} !== 3'b000) begin
         failed++;
         $display("FAIL reset_ctrl: resp/busy/error=%b expected 000",
                  {bus.pmem_resp, bus.pmem_busy, bus.pmem_error});
      end
      tests++;
      if (bus.pmem_rdata !== 128'h0) begin
         failed++;
         $display("FAIL reset_rdata: got %h expected 0", bus.pmem_rdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_first_read();
      int lat, bcnt;
      lc3b_line r;
      run_access(1'b1, 1'b0, 16'h1230, '0, 1'b0, lat, bcnt, r);
      tests++;
      if (lat !== LAT) begin failed++; $display("FAIL first_read_latency: got %0d expected %0d", lat, LAT); end
      tests++;
      if (r !== 128'h0) begin failed++; $display("FAIL first_read_rdata: got %h expected 0", r); end
      tests++;
      if (bcnt !== LAT) begin failed++; $display("FAIL first_read_busy: got %0d cycles expected %0d", bcnt, LAT); end
      tests++;
      if (bus.pmem_resp !== 1'b0) begin failed++; $display("FAIL resp_single_pulse: resp=%b after resp cycle", bus.pmem_resp); end
   endtask

   task automatic test_write_read();
      int lat, bcnt;
      lc3b_line r, d;
      d = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
      run_access(1'b0, 1'b1, 16'h1230, d, 1'b0, lat, bcnt, r);
      ref_write(16'h1230, d);
      tests++;
      if (lat !== LAT) begin failed++; $display("FAIL write_latency: got %0d expected %0d", lat, LAT); end
      run_access(1'b1, 1'b0, 16'h123F, '0, 1'b0, lat, bcnt, r);
      tests++;
      if (r !== ref_read(16'h123F)) begin failed++; $display("FAIL read_after_write: got %h expected %h", r, ref_read(16'h123F)); end
      run_access(1'b0, 1'b1, 16'h5550, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, lat, bcnt, r);
      ref_write(16'h5550, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      tests++;
      if (bus.pmem_rdata !== d) begin failed++; $display("FAIL rdata_hold_over_write: got %h expected %h", bus.pmem_rdata, d); end
   endtask

   task automatic test_random();
      int lat, bcnt;
      lc3b_line r, d;
      logic [15:0] a;
      bit is_wr;
      for (int i = 0; i < 24; i++) begin
         a = 16'h4000 | 16'($urandom_range(0, 7) << 4) | 16'($urandom_range(0, 15));
         d = {$urandom, $urandom, $urandom, $urandom};
         is_wr = 1'($urandom_range(0, 1));
         run_access(!is_wr, is_wr, a, d, 1'b0, lat, bcnt, r);
         tests++;
         if (lat !== LAT || bcnt !== LAT) begin
            failed++;
            $display("FAIL rand_timing[%0d]: latency %0d busy %0d expected %0d", i, lat, bcnt, LAT);
         end
         if (is_wr) begin
            ref_write(a, d);
         end else begin
            tests++;
            if (r !== ref_read(a)) begin failed++; $display("FAIL rand_read[%0d] addr %h: got %h expected %h", i, a, r, ref_read(a)); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt, gap;
      lc3b_line r, r2, d;
      d = 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_C3C3;
      run_access(1'b0, 1'b1, 16'h2340, d, 1'b0, lat, bcnt, r);
      ref_write(16'h2340, d);
      run_access(1'b1, 1'b0, 16'h2340, '0, 1'b1, lat, bcnt, r);
      bus.pmem_address = 16'h2340;
      gap = -1; r2 = '0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.pmem_resp) begin gap = k; r2 = bus.pmem_rdata; break; end
      end
      bus.pmem_read = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (gap !== LAT + 1) begin failed++; $display("FAIL b2b_gap: got %0d edges expected %0d", gap, LAT + 1); end
      tests++;
      if (r !== d || r2 !== d) begin failed++; $display("FAIL b2b_rdata: got %h / %h expected %h", r, r2, d); end
   endtask

   task automatic test_abort();
      int lat, bcnt;
      lc3b_line r, d1;
      bit seen;
      d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      run_access(1'b0, 1'b1, 16'h6660, d1, 1'b0, lat, bcnt, r);
      ref_write(16'h6660, d1);
      bus.pmem_write = 1'b1; bus.pmem_address = 16'h6660; bus.pmem_wdata = ~d1;
      @(posedge clk); #1;
      tests++;
      if (bus.pmem_busy !== 1'b1) begin failed++; $display("FAIL abort_accept: busy=%b expected 1", bus.pmem_busy); end
      @(posedge clk); #1;
      bus.pmem_write = 1'b0;
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #1; seen |= bus.pmem_resp; end
      tests++;
      if (seen !== 1'b0 || bus.pmem_busy !== 1'b0) begin
         failed++;
         $display("FAIL abort_no_resp: resp_seen=%b busy=%b expected 0/0", seen, bus.pmem_busy);
      end
      run_access(1'b1, 1'b0, 16'h6660, '0, 1'b0, lat, bcnt, r);
      tests++;
      if (r !== ref_read(16'h6660)) begin failed++; $display("FAIL abort_no_commit: got %h expected %h", r, ref_read(16'h6660)); end
   endtask

   task automatic test_conflict();
      int lat, bcnt;
      lc3b_line r;
      tests++;
      if (bus.pmem_error !== 1'b0) begin failed++; $display("FAIL error_clear_before: got %b expected 0", bus.pmem_error); end
      run_access(1'b1, 1'b1, 16'h2340, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, 1'b0, lat, bcnt, r);
      tests++;
      if (lat !== LAT || r !== ref_read(16'h2340)) begin
         failed++;
         $display("FAIL conflict_read: latency %0d rdata %h expected %0d / %h", lat, r, LAT, ref_read(16'h2340));
      end
      tests++;
      if (bus.pmem_error !== 1'b1) begin failed++; $display("FAIL conflict_error: got %b expected 1", bus.pmem_error); end
      run_access(1'b1, 1'b0, 16'h2340, '0, 1'b0, lat, bcnt, r);
      tests++;
      if (r !== ref_read(16'h2340)) begin failed++; $display("FAIL conflict_no_write: got %h expected %h", r, ref_read(16'h2340)); end
      tests++;
      if (bus.pmem_error !== 1'b1) begin failed++; $display("FAIL error_sticky: got %b expected 1", bus.pmem_error); end
   endtask

   task automatic test_reset_mid_busy();
      int lat, bcnt;
      lc3b_line r;
      bit seen;
      bus.pmem_write = 1'b1; bus.pmem_address = 16'h7770;
      bus.pmem_wdata = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      tests++;
      if ({bus.pmem_resp, bus.pmem_busy, bus.pmem_error} !== 3'b000 || bus.pmem_rdata !== 128'h0) begin
         failed++;
         $display("FAIL rst_mid_busy_outputs: resp/busy/error=%b rdata=%h expected 000 / 0",
                  {bus.pmem_resp, bus.pmem_busy, bus.pmem_error}, bus.pmem_rdata);
      end
      bus.pmem_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      ref_mem.delete();
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #1; seen |= bus.pmem_resp; end
      tests++;
      if (seen !== 1'b0) begin failed++; $display("FAIL rst_no_resp: resp_seen=%b expected 0", seen); end
      run_access(1'b1, 1'b0, 16'h7770, '0, 1'b0, lat, bcnt, r);
      tests++;
      if (r !== ref_read(16'h7770)) begin failed++; $display("FAIL rst_no_commit: got %h expected %h", r, ref_read(16'h7770)); end
      run_access(1'b1, 1'b0, 16'h1230, '0, 1'b0, lat, bcnt, r);
      tests++;
      if (r !== ref_read(16'h1230)) begin failed++; $display("FAIL rst_clears_valid: got %h expected %h", r, ref_read(16'h1230)); end
   endtask

   initial begin
      test_reset();
      test_first_read();
      test_write_read();
      test_random();
      test_back_to_back();
      test_abort();
      test_conflict();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
